// File: rtl/card_link_pkg.sv
// Shared definitions for the card link framing (transmitter now, matching decoder later).
package card_link_pkg;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        DEAL     = 2'b00,
        HIT      = 2'b01,
        FINISHED = 2'b10,
        RESULT   = 2'b11
    } frame_type_t;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_SOF  = 3'd1,
        TX_HDR  = 3'd2,
        TX_CNT  = 3'd3,
        TX_RD   = 3'd4,
        TX_DATA = 3'd5,
        TX_CHK  = 3'd6,
        TX_DONE = 3'd7
    } tx_state_t;

    function automatic logic [7:0] pack_header(input frame_type_t ftype, input logic [3:0] ch);
        return {ftype, 2'b00, ch};
    endfunction

endpackage

// File: rtl/card_frame_tx_if.sv
// Request, card-store and uart FIFO signals of the card frame transmitter.
interface card_frame_tx_if #(
    parameter int N_CH   = 2,
    parameter int CARD_W = 6
);
    logic [N_CH-1:0]   req;
    logic [2*N_CH-1:0] req_type;
    logic [8*N_CH-1:0] req_count;
    logic [N_CH-1:0]   ack;
    logic              rd_en;
    logic [3:0]        rd_ch;
    logic [7:0]        rd_idx;
    logic [CARD_W-1:0] rd_data;
    logic              tx_full;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              busy;
    logic              frame_err;

    modport master (
        input  req, req_type, req_count, rd_data, tx_full,
        output ack, rd_en, rd_ch, rd_idx, wr_uart, w_data, busy, frame_err
    );

    modport slave (
        output req, req_type, req_count, rd_data, tx_full,
        input  ack, rd_en, rd_ch, rd_idx, wr_uart, w_data, busy, frame_err
    );
endinterface

// File: rtl/card_frame_tx_arb.sv
// Round-robin arbiter: grants the first requester after the last granted channel.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] ptr_q;

    always_comb begin
        int c;
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        c            = 0;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(ptr_q) + i) % N;
            if (!any && req[c]) begin
                any             = 1'b1;
                grant_idx       = IW'(c);
                grant_onehot[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst)         ptr_q <= IW'(N - 1);
        else if (advance) ptr_q <= grant_idx;
    end

endmodule

// File: rtl/card_frame_tx.sv
// Serialises per-channel card frames (SOF, header, count, cards, XOR checksum) into the uart TX FIFO.
module card_frame_tx
    import card_link_pkg::*;
#(
    parameter int         N_CH      = 2,
    parameter int         MAX_CARDS = 8,
    parameter int         CARD_W    = 6,
    parameter logic [7:0] SOF_BYTE  = SOF_BYTE_DEF
) (
    input logic           clk,
    input logic           rst,
    card_frame_tx_if.master bus
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [2:0] IDLE = TX_IDLE;
    localparam logic [2:0] SOF  = TX_SOF;
    localparam logic [2:0] HDR  = TX_HDR;
    localparam logic [2:0] CNT  = TX_CNT;
    localparam logic [2:0] RD   = TX_RD;
    localparam logic [2:0] DATA = TX_DATA;
    localparam logic [2:0] CHK  = TX_CHK;
    localparam logic [2:0] DONE = TX_DONE;

    logic [2:0]        state;
    logic [3:0]        ch_q;
    frame_type_t       type_q;
    logic [7:0]        count_q;
    logic [7:0]        idx_q;
    logic [7:0]        chk_q;
    logic [CARD_W-1:0] hold_q;
    logic              first_q;
    logic [N_CH-1:0]   ack_oh_q;

    logic [N_CH-1:0]   gnt_oh;
    logic [IW-1:0]     gnt_idx;
    logic              any_req;
    logic              grant;
    logic [1:0]        sel_type;
    logic [7:0]        sel_count;
    logic              clamped;
    logic [7:0]        count_lat;
    logic [CARD_W-1:0] cur_card;
    logic [8:0]        idx_next;
    logic              accept;

    assign grant = (state == IDLE) && any_req;

    rr_arbiter #(.N(N_CH)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (bus.req),
        .advance      (grant),
        .grant_onehot (gnt_oh),
        .grant_idx    (gnt_idx),
        .any          (any_req)
    );

    always_comb begin
        sel_type  = '0;
        sel_count = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_oh[i]) begin
                sel_type  |= bus.req_type[2*i +: 2];
                sel_count |= bus.req_count[8*i +: 8];
            end
        end
    end

    assign clamped   = sel_count > 8'(MAX_CARDS);
    assign count_lat = clamped ? 8'(MAX_CARDS) : sel_count;
    assign cur_card  = first_q ? bus.rd_data : hold_q;
    assign idx_next  = {1'b0, idx_q} + 9'd1;

    // The grant is combinational in IDLE; gating with rst keeps frame_err quiet while reset is held.
    assign bus.frame_err = grant & clamped & rst;
    assign bus.busy      = (state != IDLE);
    assign bus.rd_ch     = ch_q;
    assign bus.rd_idx    = idx_q;
    assign bus.rd_en     = (state == RD);
    assign bus.ack       = (state == DONE) ? ack_oh_q : '0;
    assign accept        = bus.wr_uart;

    always_comb begin
        bus.wr_uart = 1'b0;
        bus.w_data  = '0;
        case (state)
            SOF: begin
                bus.wr_uart = !bus.tx_full;
                bus.w_data  = SOF_BYTE;
            end
            HDR: begin
                bus.wr_uart = !bus.tx_full;
                bus.w_data  = pack_header(type_q, ch_q);
            end
            CNT: begin
                bus.wr_uart = !bus.tx_full;
                bus.w_data  = count_q;
            end
            DATA: begin
                bus.wr_uart                = !bus.tx_full;
                bus.w_data[CARD_W-1:0]     = cur_card;
            end
            CHK: begin
                bus.wr_uart = !bus.tx_full;
                bus.w_data  = chk_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ch_q     <= '0;
            type_q   <= DEAL;
            count_q  <= '0;
            idx_q    <= '0;
            chk_q    <= '0;
            hold_q   <= '0;
            first_q  <= 1'b0;
            ack_oh_q <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    ch_q     <= 4'(gnt_idx);
                    type_q   <= frame_type_t'(sel_type);
                    count_q  <= count_lat;
                    ack_oh_q <= gnt_oh;
                    chk_q    <= '0;
                    idx_q    <= '0;
                    state    <= SOF;
                end
                SOF: if (accept) state <= HDR;
                HDR: if (accept) begin
                    chk_q <= chk_q ^ bus.w_data;
                    state <= CNT;
                end
                CNT: if (accept) begin
                    chk_q <= chk_q ^ bus.w_data;
                    state <= (count_q != 8'd0) ? RD : CHK;
                end
                RD: begin
                    first_q <= 1'b1;
                    state   <= DATA;
                end
                DATA: begin
                    // The card is only valid the cycle after rd_en; keep it for stalled cycles.
                    first_q <= 1'b0;
                    if (first_q) hold_q <= bus.rd_data;
                    if (accept) begin
                        chk_q <= chk_q ^ bus.w_data;
                        idx_q <= idx_next[7:0];
                        state <= (idx_next < {1'b0, count_q}) ? RD : CHK;
                    end
                end
                CHK:  if (accept) state <= DONE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_frame_tx.sv
// Directed bench for card_frame_tx: byte streams, latency, arbitration order, backpressure and reset abort.
module tb_card_frame_tx;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    card_frame_tx_if #(.N_CH(2), .CARD_W(6)) bus();

    card_frame_tx #(
        .N_CH      (2),
        .MAX_CARDS (8),
        .CARD_W    (6),
        .SOF_BYTE  (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Card store: data valid the cycle after rd_en, scrambled otherwise.
    logic [5:0] store [2][16];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= store[bus.rd_ch[0]][bus.rd_idx[3:0]];
        else           bus.rd_data <= 6'($urandom);
    end

    byte_q_t          bytes;
    logic [1:0]       acks [$];
    logic             busy_hist [$];
    bit               rec_busy = 1'b0;
    int               n_rd = 0, n_ferr = 0, ferr_cyc = -1, wr_during_full = 0, ack_multi = 0;

    always @(negedge clk) begin
        if (bus.wr_uart) begin
            bytes.push_back(bus.w_data);
            if (bus.tx_full) wr_during_full++;
        end
        if (bus.rd_en) n_rd++;
        if (|bus.ack) acks.push_back(bus.ack);
        if ($countones(bus.ack) > 1) ack_multi++;
        if (bus.frame_err) begin
            n_ferr++;
            ferr_cyc = cyc;
        end
        if (rec_busy) busy_hist.push_back(bus.busy);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag, input byte_q_t exp);
        check({tag, "_len"}, 32'(bytes.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_b%0d", tag, i),
                  (i < bytes.size()) ? 32'(bytes[i]) : 32'hBAD, 32'(exp[i]));
    endtask

    task automatic clear_mon();
        bytes.delete();
        acks.delete();
        n_rd   = 0;
        n_ferr = 0;
        ferr_cyc = -1;
    endtask

    // Called at posedge+1 of the grant cycle; drives tx_full windows (cycles after grant) until ack.
    task automatic wait_ack(input int f0a, input int f0b, input int f1a, input int f1b,
                            input int drop_at, output int lat);
        int k;
        int rel;
        bit seen;
        k    = cyc;
        seen = 1'b0;
        lat  = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (|bus.ack) begin
                seen = 1'b1;
                lat  = cyc - k;
                break;
            end
            @(posedge clk);
            #1;
            rel = cyc - k;
            bus.tx_full = ((rel >= f0a) && (rel <= f0b)) || ((rel >= f1a) && (rel <= f1b));
            if (rel == drop_at) begin
                bus.req       = '0;
                bus.req_type  = '1;
                bus.req_count = '1;
            end
        end
        bus.tx_full = 1'b0;
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_req();
        @(posedge clk);
        #1;
        bus.req = '0;
    endtask

    initial begin
        int lat;
        int zeros, run, maxrun;
        bit started;

        rst = 1'b0;
        bus.req = '0;
        bus.req_type = '0;
        bus.req_count = '0;
        bus.tx_full = 1'b0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 16; i++) store[c][i] = 6'h3F;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_uart", 32'(bus.wr_uart), 32'd0);
        check("rst_w_data", 32'(bus.w_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame: ch0 deal, 2 cards.
        clear_mon();
        store[0][0] = 6'h11;
        store[0][1] = 6'h2C;
        bus.req_type  = 4'b00_00;
        bus.req_count = {8'd0, 8'd2};
        bus.req       = 2'b01;
        wait_ack(-1, -1, -1, -1, -1, lat);
        end_req();
        check_stream("s1", '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h2C, 8'h3F});
        check("s1_ack_lat", 32'(lat), 32'd9);
        check("s1_ack_vec", (acks.size() > 0) ? 32'(acks[0]) : 32'hBAD, 32'h1);
        check("s1_rd_pulses", 32'(n_rd), 32'd2);
        check("s1_frame_err", 32'(n_ferr), 32'd0);

        // Empty frame: ch1 finished, 0 cards.
        clear_mon();
        bus.req_type  = 4'b10_00;
        bus.req_count = {8'd0, 8'd0};
        bus.req       = 2'b10;
        wait_ack(-1, -1, -1, -1, -1, lat);
        end_req();
        check_stream("s2", '{8'hA5, 8'h81, 8'h00, 8'h81});
        check("s2_ack_lat", 32'(lat), 32'd5);
        check("s2_ack_vec", (acks.size() > 0) ? 32'(acks[0]) : 32'hBAD, 32'h2);
        check("s2_rd_pulses", 32'(n_rd), 32'd0);

        // Both channels requesting for three frames.
        clear_mon();
        busy_hist.delete();
        bus.req_type  = 4'b10_00;
        bus.req_count = {8'd0, 8'd2};
        bus.req       = 2'b11;
        rec_busy      = 1'b1;
        for (int f = 0; f < 3; f++) wait_ack(-1, -1, -1, -1, -1, lat);
        rec_busy = 1'b0;
        end_req();
        check("s3_ack_count", 32'(acks.size()), 32'd3);
        check("s3_grant0", (acks.size() > 0) ? 32'(acks[0]) : 32'hBAD, 32'h1);
        check("s3_grant1", (acks.size() > 1) ? 32'(acks[1]) : 32'hBAD, 32'h2);
        check("s3_grant2", (acks.size() > 2) ? 32'(acks[2]) : 32'hBAD, 32'h1);
        check_stream("s3", '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h2C, 8'h3F,
                             8'hA5, 8'h81, 8'h00, 8'h81,
                             8'hA5, 8'h00, 8'h02, 8'h11, 8'h2C, 8'h3F});
        zeros = 0; run = 0; maxrun = 0; started = 1'b0;
        foreach (busy_hist[i]) begin
            if (busy_hist[i]) begin
                started = 1'b1;
                run = 0;
            end else if (started) begin
                zeros++;
                run++;
                if (run > maxrun) maxrun = run;
            end
        end
        check("s3_busy_low_total", 32'(zeros), 32'd2);
        check("s3_busy_low_run", 32'(maxrun), 32'd1);

        // Backpressure on CNT and across the second RD/DATA.
        clear_mon();
        wr_during_full = 0;
        bus.req_type  = 4'b00_00;
        bus.req_count = {8'd0, 8'd2};
        bus.req       = 2'b01;
        wait_ack(3, 7, 11, 15, -1, lat);
        end_req();
        check_stream("s4", '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h2C, 8'h3F});
        check("s4_wr_while_full", 32'(wr_during_full), 32'd0);
        check("s4_ack_lat", 32'(lat), 32'd18);
        check("s4_rd_pulses", 32'(n_rd), 32'd2);

        // Oversized request clamped to 8 cards; request withdrawn and altered mid-frame.
        clear_mon();
        store[0][0] = 6'h03; store[0][1] = 6'h08; store[0][2] = 6'h0D; store[0][3] = 6'h12;
        store[0][4] = 6'h17; store[0][5] = 6'h1C; store[0][6] = 6'h21; store[0][7] = 6'h26;
        bus.req_type  = 4'b00_00;
        bus.req_count = {8'd0, 8'd12};
        bus.req       = 2'b01;
        lat = cyc;
        ferr_cyc = -1;
        begin
            int k0;
            k0 = cyc;
            wait_ack(-1, -1, -1, -1, 4, lat);
            check("s5_ferr_at_grant", 32'(ferr_cyc), 32'(k0));
        end
        end_req();
        check_stream("s5", '{8'hA5, 8'h00, 8'h08, 8'h03, 8'h08, 8'h0D, 8'h12,
                             8'h17, 8'h1C, 8'h21, 8'h26, 8'h10});
        check("s5_ferr_pulses", 32'(n_ferr), 32'd1);
        check("s5_rd_pulses", 32'(n_rd), 32'd8);
        check("s5_ack_lat", 32'(lat), 32'd21);
        check("s5_ack_vec", (acks.size() > 0) ? 32'(acks[0]) : 32'hBAD, 32'h1);

        // Reset during the first DATA cycle, then a fresh frame with both channels requesting.
        clear_mon();
        store[0][0] = 6'h11;
        store[0][1] = 6'h2C;
        bus.req_type  = 4'b00_00;
        bus.req_count = {8'd0, 8'd2};
        bus.req       = 2'b01;
        repeat (5) @(posedge clk);
        #2;
        check("s6_pre_rst_wr", 32'(bus.wr_uart), 32'd1);
        rst = 1'b0;
        #1;
        check("s6_rst_wr_uart", 32'(bus.wr_uart), 32'd0);
        check("s6_rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("s6_rst_ack", 32'(bus.ack), 32'd0);
        check("s6_rst_busy", 32'(bus.busy), 32'd0);
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        bus.req_type  = 4'b11_01;
        bus.req_count = {8'd3, 8'd1};
        bus.req       = 2'b11;
        wait_ack(-1, -1, -1, -1, -1, lat);
        end_req();
        check_stream("s6", '{8'hA5, 8'h40, 8'h01, 8'h11, 8'h50});
        check("s6_ack_vec", (acks.size() > 0) ? 32'(acks[0]) : 32'hBAD, 32'h1);
        check("s6_ack_lat", 32'(lat), 32'd7);

        repeat (3) @(posedge clk);
        check("ack_onehot", 32'(ack_multi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
